// File: rtl/multi_square_object.sv
// Multi-rectangle renderer with per-frame double-buffered attributes,
// fixed-priority overlap resolution and pixel/frame collision flags.
module multi_square_object #(
    parameter int           NUM_OBJ              = 4,
    parameter int           COORD_W              = 11,
    parameter int           SIZE_W               = 8,
    parameter logic [7:0]   TRANSPARENT_ENCODING = 8'hFF,
    localparam int          IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic [COORD_W-1:0]               pixelX,
    input  logic [COORD_W-1:0]               pixelY,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]  topLeftX,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]  topLeftY,
    input  logic [NUM_OBJ-1:0][SIZE_W-1:0]   objWidth,
    input  logic [NUM_OBJ-1:0][SIZE_W-1:0]   objHeight,
    input  logic [NUM_OBJ-1:0][7:0]          objColor,
    input  logic [NUM_OBJ-1:0]               objEnable,
    output logic                             drawingRequest,
    output logic [7:0]                       RGBout,
    output logic [IW-1:0]                    hitIndex,
    output logic [NUM_OBJ-1:0]               hitVector,
    output logic [COORD_W-1:0]               offsetX,
    output logic [COORD_W-1:0]               offsetY,
    output logic                             pixelCollision,
    output logic                             lastFrameCollision
);

    // Two guard bits so position + size never wraps
    localparam int AW = COORD_W + 2;

    logic [NUM_OBJ-1:0][COORD_W-1:0] sh_x;
    logic [NUM_OBJ-1:0][COORD_W-1:0] sh_y;
    logic [NUM_OBJ-1:0][SIZE_W-1:0]  sh_w;
    logic [NUM_OBJ-1:0][SIZE_W-1:0]  sh_h;
    logic [NUM_OBJ-1:0][7:0]         sh_c;
    logic [NUM_OBJ-1:0]              sh_en;

    logic [NUM_OBJ-1:0]  hit_c;
    logic [IW-1:0]       win_c;
    logic [7:0]          rgb_c;
    logic [COORD_W-1:0]  ox_c;
    logic [COORD_W-1:0]  oy_c;
    logic [4:0]          cnt_c;
    logic                coll_c;
    logic                sticky;

    logic signed [AW-1:0] px_s;
    logic signed [AW-1:0] py_s;
    logic signed [AW-1:0] xs;
    logic signed [AW-1:0] ys;
    logic signed [AW-1:0] xe;
    logic signed [AW-1:0] ye;

    // Shadow attributes: reloaded only at frame start
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_w  <= '0;
            sh_h  <= '0;
            sh_c  <= '0;
            sh_en <= '0;
        end else if (startOfFrame) begin
            sh_x  <= topLeftX;
            sh_y  <= topLeftY;
            sh_w  <= objWidth;
            sh_h  <= objHeight;
            sh_c  <= objColor;
            sh_en <= objEnable;
        end
    end

    // Parallel inside tests, then lowest-index-wins selection
    always_comb begin
        hit_c = '0;
        win_c = '0;
        rgb_c = TRANSPARENT_ENCODING;
        ox_c  = '0;
        oy_c  = '0;
        cnt_c = '0;
        px_s  = AW'(pixelX);
        py_s  = AW'(pixelY);
        xs    = '0;
        ys    = '0;
        xe    = '0;
        ye    = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            xs = {{2{sh_x[i][COORD_W-1]}}, sh_x[i]};
            ys = {{2{sh_y[i][COORD_W-1]}}, sh_y[i]};
            xe = xs + AW'(sh_w[i]);
            ye = ys + AW'(sh_h[i]);
            hit_c[i] = sh_en[i] && (px_s >= xs) && (px_s < xe)
                                && (py_s >= ys) && (py_s < ye);
            if (hit_c[i]) begin
                win_c = IW'(i);
                rgb_c = sh_c[i];
                ox_c  = COORD_W'(px_s - xs);
                oy_c  = COORD_W'(py_s - ys);
            end
            cnt_c = cnt_c + 5'(hit_c[i]);
        end
        coll_c = (cnt_c >= 5'd2);
    end

    // Registered pixel response
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'h00;
            hitIndex       <= '0;
            hitVector      <= '0;
            offsetX        <= '0;
            offsetY        <= '0;
            pixelCollision <= 1'b0;
        end else begin
            drawingRequest <= |hit_c;
            RGBout         <= rgb_c;
            hitIndex       <= win_c;
            hitVector      <= hit_c;
            offsetX        <= ox_c;
            offsetY        <= oy_c;
            pixelCollision <= coll_c;
        end
    end

    // Sticky collision, handed over at frame start (incl. that cycle)
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sticky             <= 1'b0;
            lastFrameCollision <= 1'b0;
        end else if (startOfFrame) begin
            lastFrameCollision <= sticky | coll_c;
            sticky             <= 1'b0;
        end else if (coll_c) begin
            sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_square_object.sv
// Randomised and directed checks of multi_square_object against an
// integer-arithmetic behavioural model.
module tb_multi_square_object;

    localparam int N  = 4;
    localparam int CW = 11;
    localparam int SW = 8;

    logic                  clk;
    logic                  resetN;
    logic                  startOfFrame;
    logic [CW-1:0]         pixelX;
    logic [CW-1:0]         pixelY;
    logic [N-1:0][CW-1:0]  topLeftX;
    logic [N-1:0][CW-1:0]  topLeftY;
    logic [N-1:0][SW-1:0]  objWidth;
    logic [N-1:0][SW-1:0]  objHeight;
    logic [N-1:0][7:0]     objColor;
    logic [N-1:0]          objEnable;
    logic                  drawingRequest;
    logic [7:0]            RGBout;
    logic [1:0]            hitIndex;
    logic [N-1:0]          hitVector;
    logic [CW-1:0]         offsetX;
    logic [CW-1:0]         offsetY;
    logic                  pixelCollision;
    logic                  lastFrameCollision;

    int total = 0;
    int bad   = 0;

    // model state: frame-latched attributes as plain integers
    int sx[N], sy[N], sw[N], sh[N], sc[N], se[N];
    int m_sticky, m_last;

    multi_square_object dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .pixelX            (pixelX),
        .pixelY            (pixelY),
        .topLeftX          (topLeftX),
        .topLeftY          (topLeftY),
        .objWidth          (objWidth),
        .objHeight         (objHeight),
        .objColor          (objColor),
        .objEnable         (objEnable),
        .drawingRequest    (drawingRequest),
        .RGBout            (RGBout),
        .hitIndex          (hitIndex),
        .hitVector         (hitVector),
        .offsetX           (offsetX),
        .offsetY           (offsetY),
        .pixelCollision    (pixelCollision),
        .lastFrameCollision(lastFrameCollision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            sx[i] = 0; sy[i] = 0; sw[i] = 0;
            sh[i] = 0; sc[i] = 0; se[i] = 0;
        end
        m_sticky = 0;
        m_last   = 0;
    endtask

    task automatic set_obj(input int i, input int x, input int y,
                           input int w, input int h, input int c,
                           input bit en);
        topLeftX[i]  = CW'(x);
        topLeftY[i]  = CW'(y);
        objWidth[i]  = SW'(w);
        objHeight[i] = SW'(h);
        objColor[i]  = 8'(c);
        objEnable[i] = en;
    endtask

    // One pixel: drive, predict, clock, compare
    task automatic step(input int px, input int py, input bit sof);
        int  cnt, win, ox, oy, rgb;
        logic [N-1:0] vec;
        @(negedge clk);
        pixelX = CW'(px);
        pixelY = CW'(py);
        startOfFrame = sof;
        cnt = 0; win = -1; ox = 0; oy = 0; rgb = 'hFF; vec = '0;
        for (int i = 0; i < N; i++) begin
            if (se[i] != 0 && px >= sx[i] && px < sx[i] + sw[i]
                && py >= sy[i] && py < sy[i] + sh[i]) begin
                vec[i] = 1'b1;
                cnt++;
                if (win < 0) begin
                    win = i;
                    rgb = sc[i];
                    ox  = px - sx[i];
                    oy  = py - sy[i];
                end
            end
        end
        @(posedge clk);
        #1;
        if (sof) begin
            for (int i = 0; i < N; i++) begin
                sx[i] = int'($signed(topLeftX[i]));
                sy[i] = int'($signed(topLeftY[i]));
                sw[i] = int'(objWidth[i]);
                sh[i] = int'(objHeight[i]);
                sc[i] = int'(objColor[i]);
                se[i] = int'(objEnable[i]);
            end
            m_last   = (m_sticky != 0 || cnt >= 2) ? 1 : 0;
            m_sticky = 0;
        end else if (cnt >= 2) begin
            m_sticky = 1;
        end
        startOfFrame = 1'b0;
        chk("drq",  32'(drawingRequest), 32'(win >= 0));
        chk("rgb",  32'(RGBout), 32'(rgb));
        chk("idx",  32'(hitIndex), 32'(win < 0 ? 0 : win));
        chk("vec",  32'(hitVector), 32'(vec));
        chk("offx", 32'(offsetX), 32'(ox));
        chk("offy", 32'(offsetY), 32'(oy));
        chk("pcol", 32'(pixelCollision), 32'(cnt >= 2));
        chk("fcol", 32'(lastFrameCollision), 32'(m_last));
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        pixelX = '0;
        pixelY = '0;
        for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 0, 1'b0);
        model_clear();
        #12;
        chk("rst_drq", 32'(drawingRequest), 32'd0);
        chk("rst_rgb", 32'(RGBout), 32'h00);
        chk("rst_vec", 32'(hitVector), 32'd0);
        chk("rst_fcol", 32'(lastFrameCollision), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // single object sweep
        set_obj(0, 100, 50, 20, 10, 'h5b, 1'b1);
        step(0, 0, 1'b1);
        for (int x = 98; x <= 121; x++) step(x, 55, 1'b0);
        step(110, 55, 1'b0);
        chk("single_rgb", 32'(RGBout), 32'h5b);
        chk("single_offx", 32'(offsetX), 32'd10);
        chk("single_offy", 32'(offsetY), 32'd5);

        // double buffering
        set_obj(0, 300, 50, 20, 10, 'h5b, 1'b1);
        step(110, 55, 1'b0);
        step(110, 55, 1'b1);
        chk("sof_old_pos", 32'(drawingRequest), 32'd1);
        step(300, 55, 1'b0);
        chk("new_pos", 32'(drawingRequest), 32'd1);
        step(100, 55, 1'b0);
        chk("old_gone", 32'(drawingRequest), 32'd0);

        // priority and collision
        set_obj(0, 10, 10, 10, 10, 'h11, 1'b1);
        set_obj(2, 15, 15, 10, 10, 'h22, 1'b1);
        step(0, 0, 1'b1);
        step(16, 16, 1'b0);
        chk("pri_rgb", 32'(RGBout), 32'h11);
        chk("pri_vec", 32'(hitVector), 32'b0101);
        chk("pri_col", 32'(pixelCollision), 32'd1);
        step(22, 22, 1'b0);
        chk("pri2_idx", 32'(hitIndex), 32'd2);
        chk("pri2_off", 32'({offsetX, offsetY}), 32'({11'd7, 11'd7}));
        step(0, 0, 1'b1);
        chk("frame_col", 32'(lastFrameCollision), 32'd1);
        step(22, 22, 1'b0);
        step(0, 0, 1'b1);
        chk("frame_nocol", 32'(lastFrameCollision), 32'd0);

        // clipping and zero width
        set_obj(1, -5, -3, 10, 10, 'h33, 1'b1);
        set_obj(3, 0, 0, 0, 10, 'h44, 1'b1);
        step(0, 0, 1'b1);
        for (int x = 0; x < 8; x++) step(x, 0, 1'b0);
        step(0, 0, 1'b0);
        chk("clip_off", 32'({offsetX, offsetY}), 32'({11'd5, 11'd3}));
        step(5, 0, 1'b0);
        chk("clip_edge", 32'(drawingRequest), 32'd0);

        // disable obj0
        set_obj(0, 10, 10, 10, 10, 'h11, 1'b0);
        step(0, 0, 1'b1);
        step(12, 12, 1'b0);
        step(16, 16, 1'b0);

        // randomised frames
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0)
                set_obj($urandom_range(N - 1),
                        $urandom_range(80) - 20, $urandom_range(80) - 20,
                        $urandom_range(25), $urandom_range(25),
                        $urandom_range(255), 1'($urandom_range(1)));
            step($urandom_range(63), $urandom_range(63),
                 $urandom_range(15) == 0);
        end

        // reset mid-frame while drawing
        set_obj(0, 10, 10, 10, 10, 'h11, 1'b1);
        step(0, 0, 1'b1);
        step(12, 12, 1'b0);
        chk("pre_rst_drq", 32'(drawingRequest), 32'd1);
        #1;
        resetN = 1'b0;
        #1;
        chk("arst_drq", 32'(drawingRequest), 32'd0);
        chk("arst_rgb", 32'(RGBout), 32'h00);
        chk("arst_off", 32'({offsetX, offsetY}), 32'd0);
        chk("arst_vec", 32'(hitVector), 32'd0);
        model_clear();
        @(negedge clk);
        resetN = 1'b1;
        step(12, 12, 1'b0);
        step(15, 15, 1'b0);
        step(12, 12, 1'b1);
        step(12, 12, 1'b0);
        chk("post_sof_drq", 32'(drawingRequest), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_square_object.md
# multi_square_object

Parametrised rectangle renderer for the VGA pipeline. It draws up to NUM_OBJ axis-aligned rectangles, each with its own runtime position, size, colour and enable. Object attributes are double-buffered and latched once per frame, so objects never tear mid-frame. The block resolves overlap by fixed priority, reports per-pixel and per-frame collisions, and feeds the colour mux like a single-object source: one drawing request, one RGB value, and the offsets of the winning object.

## Interface
- NUM_OBJ, 4: number of rectangles, 1..16; index 0 has highest priority.
- COORD_W, 11: pixel/position width.
- SIZE_W, 8: width/height field width.
- TRANSPARENT_ENCODING, 8'hFF: RGBout value when nothing is drawn.
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at frame start; latches attributes.
- pixelX, pixelY  in  COORD_W  current VGA pixel, unsigned.
- topLeftX, topLeftY  in  NUM_OBJ×COORD_W signed  live object positions.
- objWidth, objHeight  in  NUM_OBJ×SIZE_W  live object sizes, unsigned.
- objColor  in  NUM_OBJ×8  live object colours.
- objEnable  in  NUM_OBJ  live enables.
- drawingRequest  out  1  pixel inside at least one enabled object.
- RGBout  out  8  colour of the winning object, else TRANSPARENT_ENCODING.
- hitIndex  out  $clog2(NUM_OBJ) (minimum 1)  index of the winning object, 0 if none.
- hitVector  out  NUM_OBJ  per-object inside flags.
- offsetX, offsetY  out  COORD_W  pixel minus top-left of the winning object, 0 if none.
- pixelCollision  out  1  two or more objects are inside at this pixel.
- lastFrameCollision  out  1  any pixelCollision occurred during the previous frame.

## Operation
- **Shadow registers.**
  - Shadow registers hold topLeftX/Y, width, height, colour and enable for each object.
  - They load from the live inputs on the clk edge where startOfFrame = 1 and are otherwise held.
  - On reset they clear to 0, so all objects are disabled.
- **Inside test.** For object i, evaluated on shadow values only:
  - enable[i] && pixelX ≥ X[i] && pixelX < X[i]+W[i] && pixelY ≥ Y[i] && pixelY < Y[i]+H[i].
- **Arithmetic.**
  - Pixel coordinates are zero-extended; positions are sign-extended.
  - All compares and sums use COORD_W+2 signed bits, so there is no wrap. An object at X = -20 with W = 30 covers pixelX 0..9 only.
  - A width or height of 0 means the object is never inside.
  - offsets = pixel − topLeft of the winner, truncated to COORD_W. The value is always non-negative and less than the size.
- **Priority.** The winner is the lowest set index in hitVector. RGBout, hitIndex and offsets come from the winner.
- **Pixel collision.** pixelCollision = popcount(hitVector) ≥ 2.
- **Frame collision.**
  - An internal sticky bit sets on any pixelCollision.
  - On the startOfFrame edge: lastFrameCollision ← sticky OR the collision of the current cycle, and sticky ← 0.
  - A collision in the startOfFrame cycle is therefore counted in the ending frame.
- **Reset mid-frame.** All outputs and shadows clear immediately, asynchronously. Objects stay invisible until the next startOfFrame.

## Timing
- All outputs are registered.
  - A pixel presented in cycle t produces its response after the edge ending cycle t, i.e. latency 1, matching the single-object block.
- In the startOfFrame cycle, the pixel in that same cycle is evaluated with the old shadow values. New values apply from the next cycle.
- Live input changes outside the startOfFrame cycle have no effect on the output.
- Reset values of every output:
  - drawingRequest 0
  - RGBout 8'h00
  - hitIndex 0
  - hitVector 0
  - offsetX/Y 0
  - pixelCollision 0
  - lastFrameCollision 0
- The critical path is NUM_OBJ parallel compares followed by a priority mux. It must close at 25 MHz for NUM_OBJ = 16.

## Test plan
- **Single object.** Obj0 at (100,50), 20×10, colour 8'h5b, enabled, latched by startOfFrame.
  - Sweep row 55. pixelX 100..119 → drawingRequest = 1, RGBout = 5b, offsetX = 0..19, offsetY = 5.
  - pixelX 99 and 120 → RGBout = FF, offsets 0. Response appears one cycle after each pixel.
- **Priority and collision.** Obj0 (10,10) 10×10 colour 8'h11; obj2 (15,15) 10×10 colour 8'h22.
  - Pixel (16,16) → RGBout = 11, hitIndex = 0, hitVector = 0101, pixelCollision = 1.
  - Pixel (22,22) → RGBout = 22, hitIndex = 2, offsets (7,7), pixelCollision = 0.
  - At the next startOfFrame, lastFrameCollision = 1; one frame later with no overlap, it returns to 0.
- **Double buffering.**
  - Change live topLeftX of obj0 from 100 to 300 mid-frame → output unchanged.
  - After startOfFrame, pixel (300,55) draws and pixel (100,55) does not.
  - Same-cycle check: a pixel presented with the startOfFrame pulse uses the old position.
- **Clipping and zero size.**
  - Obj1 at (-5,-3), 10×10 → pixel (0,0) gives offsets (5,3); pixel (5,0) is not drawn.
  - Obj3 with W = 0 → never drawn anywhere, even with enable = 1.
- **Reset mid-frame.**
  - Assert resetN = 0 while drawingRequest = 1 → all outputs 0 asynchronously.
  - After release, no object is drawn until startOfFrame, even with live inputs valid.
- **Disable.** Clear objEnable[0] and pulse startOfFrame → obj0 region shows the next priority object or transparent FF.
